// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Purpose  : Types and helpers shared by the UART transmit and receive |
// |            blocks. Holds the transmit state encoding and the         |
// |            clock-cycles-per-bit calculation.                         |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Transmit frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Whole clock cycles per serial bit. The division truncates, so the real
  // baud rate is never below the requested one.
  function automatic int clks_per_bit(input int clk_freq_mhz, input int baud_rate);
    longint unsigned clk_hz;
    clk_hz = longint'(clk_freq_mhz) * 64'd1_000_000;
    return int'(clk_hz / longint'(baud_rate));
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_sync_fifo                                            |
// | Purpose  : Single-clock first-word-fall-through FIFO. o_data always  |
// |            shows the oldest entry, so a pop consumes it on the edge. |
// | Ports    : clk, rst_n (async, active-high)                           |
// |            i_push/i_data  write request and data (ignored when full) |
// |            i_pop          read request (ignored when empty)          |
// |            o_data         head entry                                 |
// |            o_count        occupancy 0..DEPTH                         |
// |            o_full/o_empty flags derived from the registered count    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // Acceptance uses the registered flags only, so a push into a full FIFO is
  // refused even when a pop frees a slot on the same edge.
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop  & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_tx_buffered                                          |
// | Purpose  : UART transmitter with a byte FIFO in front. Frames are    |
// |            start(0), 8 data bits LSB first, optional parity, stop(1).|
// | Ports    : clk, rst_n (async, active-high)                           |
// |            i_data/i_valid  byte push, taken when o_ready is high     |
// |            o_ready         FIFO not full                             |
// |            o_tx            registered serial line, idle high         |
// |            o_busy          frame in flight or bytes queued           |
// |            o_count         queued bytes, not counting the one sent   |
// |            o_overflow      sticky, push attempted while full         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_tx_buffered #(
  parameter int CLK_FREQ_MHZ = 27,
  parameter int BAUD_RATE    = 115200,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow
);

  import uart_pkg::*;

  localparam int            CPB      = clks_per_bit(CLK_FREQ_MHZ, BAUD_RATE);
  localparam int            BCW      = $clog2(CPB + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CPB - 1);
  localparam logic          PAR_EN   = (PARITY_EN != 0);
  localparam logic          PAR_INV  = (PARITY_ODD != 0);

  uart_state_e     state_q, state_d;
  logic [BCW-1:0]  bit_cyc_q, bit_cyc_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            overflow_q, overflow_d;

  logic            fifo_pop;
  logic [7:0]      fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            bit_end;
  logic            load;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_count (o_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_ready    = ~fifo_full;
  assign o_tx       = tx_q;
  assign o_busy     = (state_q != IDLE) | ~fifo_empty;
  assign o_overflow = overflow_q;
  assign bit_end    = (bit_cyc_q == BIT_LAST);

  always_comb begin
    state_d    = state_q;
    bit_cyc_d  = bit_cyc_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    overflow_d = overflow_q | (i_valid & fifo_full);

    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        bit_cyc_d = '0;
        if (!fifo_empty) load = 1'b1;
      end

      START: begin
        if (bit_end) begin
          bit_cyc_d = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          bit_cyc_d = bit_cyc_q + BCW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          bit_cyc_d = '0;
          if (bit_idx_q == 3'd7) begin
            if (PAR_EN) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // The next data bit is shift_q[1]; it becomes shift_q[0] after the shift.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cyc_d = bit_cyc_q + BCW'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          bit_cyc_d = '0;
          tx_d      = 1'b1;
          state_d   = STOP;
        end else begin
          bit_cyc_d = bit_cyc_q + BCW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          bit_cyc_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          bit_cyc_d = bit_cyc_q + BCW'(1);
        end
      end

      default: begin
        tx_d      = 1'b1;
        bit_cyc_d = '0;
        state_d   = IDLE;
      end
    endcase

    // Pop the head byte and begin its start bit on this same edge.
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_rdata;
      parity_d  = (^fifo_rdata) ^ PAR_INV;
      tx_d      = 1'b0;
      bit_cyc_d = '0;
      bit_idx_d = 3'd0;
      state_d   = START;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      bit_cyc_q  <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cyc_q  <= bit_cyc_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule : uart_tx_buffered
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_uart_tx_buffered                                       |
// | Purpose  : Scoreboard bench. A timing model predicts when each       |
// |            accepted byte starts its frame; a monitor on o_tx pops    |
// |            those predictions and checks every bit cycle by cycle.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_uart_tx_buffered;

  localparam int CPB    = 27_000_000 / 115200;    // 234
  localparam int FB     = 11;                     // start + 8 + parity + stop
  localparam int L      = CPB * FB;
  localparam int DEPTH  = 8;
  localparam int CPB_F  = 27_000_000 / 3_000_000; // 9

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rst_f = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_tx, o_busy, o_overflow;
  logic [3:0] o_count;

  logic [7:0] d_odd = 8'h00, d_np = 8'h00;
  logic       v_odd = 1'b0, v_np = 1'b0;
  logic       rdy_odd, tx_odd, busy_odd, ovf_odd;
  logic       rdy_np, tx_np, busy_np, ovf_np;
  logic [3:0] cnt_odd, cnt_np;

  always #5 clk = ~clk;

  uart_tx_buffered u_dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  uart_tx_buffered #(.BAUD_RATE(3_000_000), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_f), .i_data(d_odd), .i_valid(v_odd),
    .o_ready(rdy_odd), .o_tx(tx_odd), .o_busy(busy_odd), .o_count(cnt_odd),
    .o_overflow(ovf_odd)
  );

  uart_tx_buffered #(.BAUD_RATE(3_000_000), .PARITY_EN(0)) u_np (
    .clk(clk), .rst_n(rst_f), .i_data(d_np), .i_valid(v_np),
    .o_ready(rdy_np), .o_tx(tx_np), .o_busy(busy_np), .o_count(cnt_np),
    .o_overflow(ovf_np)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         e_now   = 0;
  logic [7:0] m_q[$];
  int         m_next_free = 0;
  int         m_last_start = 0;
  bit         m_ovf = 1'b0;
  frame_t     sb_q[$];
  bit         mon_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e_now);
    end
  endtask

  // Line level of frame bit k: start, data LSB first, parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int k, input int pe, input int podd);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && pe != 0) return logic'((($countones(d) % 2) != 0) != (podd != 0));
    return 1'b1;
  endfunction

  // One clock edge plus the reference model: a byte leaves the queue at the
  // first edge where something is queued and the previous frame has ended.
  task automatic tick();
    int  cnt;
    bit  pop;
    @(posedge clk);
    e_now++;
    if (rst_n) begin
      m_q.delete();
      m_next_free = e_now;
      m_ovf = 1'b0;
    end else begin
      cnt = m_q.size();
      pop = (cnt > 0) && (e_now >= m_next_free);
      if (pop) begin
        sb_q.push_back('{m_q.pop_front(), e_now});
        m_last_start = e_now;
        m_next_free  = e_now + L;
      end
      if (i_valid) begin
        if (cnt < DEPTH) m_q.push_back(i_data);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, " o_count"},    int'(o_count),    m_q.size());
    check({tag, " o_ready"},    int'(o_ready),    int'(m_q.size() < DEPTH));
    check({tag, " o_busy"},     int'(o_busy),     int'((e_now < m_next_free) || (m_q.size() > 0)));
    check({tag, " o_overflow"}, int'(o_overflow), int'(m_ovf));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      if ((e_now >= m_next_free - 1 && e_now <= m_next_free + 1) || (e_now % 500 == 0))
        check_status("run");
    end
  endtask

  task automatic push(input logic [7:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
    check_status("push");
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    check("async reset o_tx", int'(o_tx), 1);
    check("async reset o_count", int'(o_count), 0);
    check("async reset o_ready", int'(o_ready), 1);
    check("async reset o_busy", int'(o_busy), 0);
    check("async reset o_overflow", int'(o_overflow), 0);
    m_q.delete();
    sb_q.delete();
    m_next_free = e_now;
    m_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_odd : tx_np;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_odd : busy_np;
  endfunction

  // sel 0: odd-parity instance, sel 1: parity-disabled instance.
  task automatic fast_frame(input int sel, input logic [7:0] d);
    int pe, nb, start;
    string nm;
    pe = (sel == 0) ? 1 : 0;
    nb = 10 + pe;
    nm = (sel == 0) ? "oddparity" : "noparity";
    if (sel == 0) begin d_odd = d; v_odd = 1'b1; end
    else          begin d_np  = d; v_np  = 1'b1; end
    tick();
    v_odd = 1'b0;
    v_np  = 1'b0;
    start = e_now + 1;
    for (int k = 0; k < nb; k++) begin
      while (e_now < start + k * CPB_F + CPB_F / 2) tick();
      check($sformatf("%s 0x%02h frame bit %0d", nm, d, k),
            int'(tx_of(sel)), int'(exp_bit(d, k, pe, sel == 0 ? 1 : 0)));
    end
    while (e_now < start + nb * CPB_F - 1) tick();
    check($sformatf("%s busy in last stop cycle", nm), int'(busy_of(sel)), 1);
    tick();
    check($sformatf("%s busy after frame", nm), int'(busy_of(sel)), 0);
  endtask

  // Monitor: matches every start bit on o_tx with the next predicted frame.
  initial begin : p_monitor
    frame_t cur;
    int     k, c, bad;
    bit     in_frame, stray;
    cur = '{8'h00, 0};
    k = 0; c = 0; bad = 0; in_frame = 1'b0; stray = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        in_frame = 1'b0;
        stray    = 1'b0;
      end else begin
        if (stray && o_tx) stray = 1'b0;
        if (!in_frame && !stray && o_tx == 1'b0) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected frame: o_tx low at edge %0d, expected idle 1", e_now);
            stray = 1'b1;
          end else begin
            cur = sb_q.pop_front();
            check($sformatf("frame 0x%02h start edge", cur.data), e_now, cur.start);
            in_frame = 1'b1;
            k = 0; c = 0; bad = 0;
          end
        end
        if (in_frame) begin
          if (o_tx !== exp_bit(cur.data, k, 1, 0)) bad++;
          c++;
          if (c == CPB) begin
            check($sformatf("frame 0x%02h bit %0d wrong-level cycles", cur.data, k), bad, 0);
            k++; c = 0; bad = 0;
            if (k == FB) in_frame = 1'b0;
          end
        end
      end
      mon_busy = in_frame;
    end
  end

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int guard, lows, gap;
    repeat (3) tick();
    check_status("reset");
    check("reset o_tx", int'(o_tx), 1);
    rst_n = 1'b0;
    rst_f = 1'b0;

    // Single byte straight after reset release, then one-edge latency to start.
    push(8'hA5);
    check("first push accepted", int'(o_count), 1);
    tick();
    check("start bit one edge after push", int'(o_tx), 0);
    check("count after pop", int'(o_count), 0);
    run(L + 20);
    check("idle after A5", int'(o_busy), 0);

    // Back-to-back frames with no idle gap.
    push(8'h3C);
    push(8'hC3);
    push(8'h55);
    check("three queued count", int'(o_count), 2);
    run(3 * L + 20);

    // Fill the FIFO, then overflow it.
    for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
    check("o_ready low when full", int'(o_ready), 0);
    push(8'hEE);
    check("overflow set", int'(o_overflow), 1);
    check("full count held", int'(o_count), DEPTH);
    run(5);
    check("overflow sticky", int'(o_overflow), 1);
    do_reset();

    // Reset in the middle of data bit 3 with three bytes waiting.
    push(8'h81);
    push(8'h42);
    push(8'h24);
    push(8'h18);
    check("three waiting", int'(o_count), 3);
    guard = 0;
    while (e_now < m_last_start + 4 * CPB + CPB / 2 && guard < 2 * L) begin
      tick();
      guard++;
    end
    check("reached data bit 3", int'(guard < 2 * L), 1);
    do_reset();
    lows = 0;
    for (int i = 0; i < L + 50; i++) begin
      tick();
      if (o_tx == 1'b0) lows++;
    end
    check("no frames after reset", lows, 0);
    check_status("after reset");

    // Randomised traffic: bursts and gaps.
    for (int i = 0; i < 10; i++) begin
      gap = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 800));
      run(gap);
      push(8'($urandom_range(0, 255)));
    end
    guard = 0;
    while (!(sb_q.size() == 0 && m_q.size() == 0 && e_now >= m_next_free && !mon_busy)
           && guard < 12 * L) begin
      tick();
      guard++;
    end
    check("drain within budget", int'(guard < 12 * L), 1);
    tick();
    check_status("drained");
    check("line idle after drain", int'(o_tx), 1);

    // Odd parity and parity-disabled variants.
    fast_frame(0, 8'h00);
    fast_frame(0, 8'h01);
    fast_frame(1, 8'hFF);
    fast_frame(1, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_buffered
`default_nettype wire

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLK_FREQ_MHZ, default 27, system clock frequency in MHz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter PARITY_EN, default 1, 1 = parity bit inserted after data.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-005 Parameter FIFO_DEPTH, default 8, power of two, 2..64.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-high.
REQ-008 i_data  input  8  byte to queue.
REQ-009 i_valid  input  1  push request, qualified by o_ready.
REQ-010 o_ready  output  1  FIFO not full.
REQ-011 o_tx  output  1  serial line, idle high.
REQ-012 o_busy  output  1  frame in progress or FIFO non-empty.
REQ-013 o_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.
REQ-014 o_overflow  output  1  sticky: push attempted while full.

Function
REQ-015 CLKS_PER_BIT SHALL equal CLK_FREQ_MHZ*1_000_000/BAUD_RATE (integer division); 234 at defaults.
REQ-016 Push SHALL occur on an edge where i_valid=1 and o_ready=1; o_ready SHALL derive from registered count only.
REQ-017 i_valid=1 with o_ready=0 SHALL drop the byte, leave FIFO unchanged, and set o_overflow until reset.
REQ-018 Simultaneous push and pop SHALL leave o_count unchanged; push on a full FIFO is refused even if a pop occurs that edge.
REQ-019 Frame: start bit 0, 8 data bits LSB first, parity bit if PARITY_EN, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-020 Parity bit SHALL be XOR of data bits, inverted when PARITY_ODD=1.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE -> START when FIFO non-empty: pop, latch byte into shift register, drive o_tx=0 on that same edge.
REQ-023 START -> DATA after CLKS_PER_BIT cycles; DATA -> PARITY (or STOP if PARITY_EN=0) after bit index 7 completes.
REQ-024 PARITY -> STOP after CLKS_PER_BIT cycles.
REQ-025 STOP -> START directly (pop, no idle cycle) if FIFO non-empty at end of stop bit, else -> IDLE.
REQ-026 Latency: byte pushed into an empty FIFO with FSM in IDLE at edge N SHALL show o_tx=0 after edge N+1.
REQ-027 o_tx SHALL be driven from a register (glitch-free).
REQ-028 Bit-cycle counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit index counter 0..7.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; o_count ranges 0..FIFO_DEPTH.
REQ-030 o_busy SHALL be 0 only when FSM is IDLE and o_count=0.

Reset
REQ-031 While rst_n=1: o_tx=1, o_ready=1, o_busy=0, o_count=0, o_overflow=0, FSM=IDLE, counters=0, pointers=0.
REQ-032 Reset mid-frame SHALL abort the frame immediately (o_tx=1) and discard all queued bytes.
REQ-033 First push SHALL be accepted on the first edge after rst_n falls.

Structure
REQ-034 Shared package uart_pkg SHALL hold the state enum type and a clks_per_bit constant function, shared with uart_rx/uart_tx.
REQ-035 FIFO SHALL be a sub-module uart_sync_fifo (parameterised depth/width, count, full, empty).
REQ-036 FSM, shift register, parity and bit timing SHALL reside in uart_tx_buffered.

Verification
REQ-037 Push 0xA5 at defaults -> o_tx: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 234 cycles; o_busy falls after stop.
REQ-038 Push 0x3C,0xC3,0x55 back-to-back -> three contiguous frames, no idle between stop and next start, o_count 2->1->0.
REQ-039 Push 9 bytes in 9 consecutive cycles, FSM idle -> 1st in shift reg, 8 queued, o_ready=0 at 10th edge; 10th push dropped, o_overflow=1.
REQ-040 PARITY_ODD=1, push 0x00 -> parity bit 1; PARITY_EN=0, push 0xFF -> stop bit follows data bit 7 directly.
REQ-041 Assert rst_n during DATA bit 3 with 3 bytes queued -> o_tx=1 immediately, o_count=0, no further frames after release.
REQ-042 Loopback into uart_rx at 27 MHz/115200 -> bytes 0xAA,0x55,0xA5 received, parity_error=0, framing_error=0.
